// File: rtl/axi4_lite_slave_rw_arbiter.sv
// axi4_lite_slave_rw_arbiter
//   Buffers one AXI4-Lite write (AW + W) and one read (AR) and sequences them
//   onto a single-ported word backend, one access at a time. When a write and
//   a read are both ready, they alternate (round-robin). B and R responses are
//   generated here.
//
// Optional feature: define AXI4_LITE_ARB_ADDR_CHECK_EN to reject byte addresses
//   >= MEM_DEPTH*4 with SLVERR. A rejected access makes no backend access and
//   returns rdata=0, and it takes the same state path and latency as a normal
//   access. When the macro is undefined, the upper address bits are ignored
//   (addresses alias) and every response is OKAY.
//
// Ports
//   aclk, areset                   clock, asynchronous active-high reset
//   awaddr/awvalid/awready         write address channel
//   wdata/wstrb/wvalid/wready      write data channel
//   bresp/bvalid/bready            write response channel
//   araddr/arvalid/arready         read address channel
//   rdata/rresp/rvalid/rready      read data channel
//   mem_en/mem_we/mem_addr         backend strobe (one cycle per access), direction, word address
//   mem_wdata/mem_wstrb            backend write data and byte strobes
//   mem_rdata                      backend read data, valid the cycle after a read strobe
module axi4_lite_slave_rw_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned MEM_AW     = $clog2(MEM_DEPTH)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WR_RESP = 3'd2,
        READ    = 3'd3,
        RD_CAPT = 3'd4,
        RD_RESP = 3'd5
    } state_t;

    state_t                state, state_d;
    logic                  last_wr, last_wr_d;      // 1 = last grant went to the write
    logic                  aw_full, aw_full_d, w_full, w_full_d, ar_full, ar_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr, aw_addr_d, ar_addr, ar_addr_d;
    logic [DATA_WIDTH-1:0] w_data, w_data_d;
    logic [STRB_WIDTH-1:0] w_strb, w_strb_d;
    logic                  rd_err, rd_err_d;        // remembers a rejected read past AR buffer reuse
    logic                  awready_d, wready_d, arready_d;
    logic [1:0]            bresp_d, rresp_d;
    logic                  bvalid_d, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  mem_en_d, mem_we_d;
    logic [MEM_AW-1:0]     mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic [STRB_WIDTH-1:0] mem_wstrb_d;
    logic                  wr_err_c, rd_err_c;

    // Out-of-range decode on the buffered addresses
`ifdef AXI4_LITE_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);
    assign wr_err_c = (aw_addr >= ADDR_LIMIT);
    assign rd_err_c = (ar_addr >= ADDR_LIMIT);
`else
    logic unused_addr_c;
    assign wr_err_c      = 1'b0;
    assign rd_err_c      = 1'b0;
    assign unused_addr_c = ^{aw_addr, ar_addr};
`endif

    // State, buffers and all registered outputs
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            last_wr   <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            ar_full   <= 1'b0;
            aw_addr   <= '0;
            ar_addr   <= '0;
            w_data    <= '0;
            w_strb    <= '0;
            rd_err    <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            arready   <= 1'b0;
            bresp     <= 2'b00;
            bvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= 2'b00;
            rvalid    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state     <= state_d;
            last_wr   <= last_wr_d;
            aw_full   <= aw_full_d;
            w_full    <= w_full_d;
            ar_full   <= ar_full_d;
            aw_addr   <= aw_addr_d;
            ar_addr   <= ar_addr_d;
            w_data    <= w_data_d;
            w_strb    <= w_strb_d;
            rd_err    <= rd_err_d;
            awready   <= awready_d;
            wready    <= wready_d;
            arready   <= arready_d;
            bresp     <= bresp_d;
            bvalid    <= bvalid_d;
            rdata     <= rdata_d;
            rresp     <= rresp_d;
            rvalid    <= rvalid_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_wstrb <= mem_wstrb_d;
        end
    end

    // Next-state, buffer capture and output next values
    always_comb begin
        state_d     = state;
        last_wr_d   = last_wr;
        aw_full_d   = aw_full;
        w_full_d    = w_full;
        ar_full_d   = ar_full;
        aw_addr_d   = aw_addr;
        ar_addr_d   = ar_addr;
        w_data_d    = w_data;
        w_strb_d    = w_strb;
        rd_err_d    = rd_err;
        bresp_d     = bresp;
        bvalid_d    = bvalid;
        rdata_d     = rdata;
        rresp_d     = rresp;
        rvalid_d    = rvalid;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;

        // Channel buffers fill independently of the FSM
        if (awvalid && awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (wvalid && wready) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (arvalid && arready) begin
            ar_full_d = 1'b1;
            ar_addr_d = araddr;
        end

        case (state)
            IDLE: begin
                // The write wins if it is alone, or on contention when the read went last
                if ((aw_full && w_full) && (!ar_full || !last_wr)) begin
                    state_d     = WRITE;
                    last_wr_d   = 1'b1;
                    mem_en_d    = !wr_err_c;
                    mem_we_d    = !wr_err_c;
                    mem_addr_d  = aw_addr[MEM_AW+1:2];
                    mem_wdata_d = w_data;
                    mem_wstrb_d = w_strb;
                end else if (ar_full) begin
                    state_d    = READ;
                    last_wr_d  = 1'b0;
                    rd_err_d   = rd_err_c;
                    mem_en_d   = !rd_err_c;
                    mem_addr_d = ar_addr[MEM_AW+1:2];
                end
            end
            WRITE: begin
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = wr_err_c ? 2'b10 : 2'b00;
                state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            READ: begin
                ar_full_d = 1'b0;
                state_d   = RD_CAPT;
            end
            RD_CAPT: begin
                rdata_d  = rd_err ? '0 : mem_rdata;
                rresp_d  = rd_err ? 2'b10 : 2'b00;
                rvalid_d = 1'b1;
                state_d  = RD_RESP;
            end
            RD_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Each ready is the registered inverse of its buffer's full flag
        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = !ar_full_d;
    end

endmodule
